// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - access size encodings (SZ_*)
//   - FSM state encodings (ST_*)
//   - big-endian lane offsets (OFF_*)
//   - request normalisation helpers used when the address is forced to
//     natural alignment instead of being rejected
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

    // Access size encodings as carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    // Big-endian lane offsets: byte offset 0 is the most significant byte
    localparam logic [1:0] OFF_B0 = 2'd0;  // bits 31:24
    localparam logic [1:0] OFF_B1 = 2'd1;  // bits 23:16
    localparam logic [1:0] OFF_B2 = 2'd2;  // bits 15:8
    localparam logic [1:0] OFF_B3 = 2'd3;  // bits 7:0
    localparam logic [1:0] OFF_H0 = 2'd0;  // bits 31:16
    localparam logic [1:0] OFF_H2 = 2'd2;  // bits 15:0

    // The reserved size behaves as a full word once it is let through
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] res;
        if (size == SZ_RSVD) begin
            res = SZ_WORD;
        end else begin
            res = size;
        end
        return res;
    endfunction

    // Natural alignment: halves drop bit 0, words drop both offset bits
    function automatic logic [1:0] norm_off(input logic [1:0] size,
                                            input logic [1:0] off);
        logic [1:0] res;
        case (size)
            SZ_BYTE: res = off;
            SZ_HALF: res = {off[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// -----------------------------------------------------------------------------
// dmem_lsu_lane
// Purely combinational lane logic for the big-endian 32-bit data memory.
//   i_req_size/i_req_off : raw size and byte offset of the incoming request,
//                          used only for misalignment detection
//   i_size/i_off         : latched, already-normalised size and offset
//   i_signed             : sign-extend extracted loads
//   i_rdata              : word read from memory
//   i_wdata              : right-justified store data
//   o_ext                : extracted, extended load data
//   o_merged             : read word with the addressed lane replaced
//   o_misaligned         : request is misaligned / reserved size (only when
//                          CHECK_EN is set, otherwise always 0)
// -----------------------------------------------------------------------------
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
)
(
    input  logic [1:0]  i_req_size,
    input  logic [1:0]  i_req_off,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ext,
    output logic [31:0] o_merged,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_mis;

    // Select the addressed byte and halfword lanes of the read word
    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            OFF_B0:  w_byte = i_rdata[31:24];
            OFF_B1:  w_byte = i_rdata[23:16];
            OFF_B2:  w_byte = i_rdata[15:8];
            OFF_B3:  w_byte = i_rdata[7:0];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = (i_off[1] == OFF_H2[1]) ? i_rdata[15:0] : i_rdata[31:16];
    end

    // Right-justify the lane and fill the upper bits with zero or the lane MSB
    always_comb begin
        o_ext = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_ext = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_ext = {{16{i_signed & w_half[15]}}, w_half};
            default: o_ext = i_rdata;
        endcase
    end

    // Replace only the addressed lane; a word store replaces everything
    always_comb begin
        o_merged = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                case (i_off)
                    OFF_B0:  o_merged[31:24] = i_wdata[7:0];
                    OFF_B1:  o_merged[23:16] = i_wdata[7:0];
                    OFF_B2:  o_merged[15:8]  = i_wdata[7:0];
                    OFF_B3:  o_merged[7:0]   = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_off[1] == OFF_H0[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0]  = i_wdata[15:0];
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

    // Misalignment: odd half, non-zero word offset, or reserved size
    always_comb begin
        w_mis = 1'b0;
        case (i_req_size)
            SZ_BYTE: w_mis = 1'b0;
            SZ_HALF: w_mis = i_req_off[0];
            SZ_WORD: w_mis = (i_req_off != 2'b00);
            default: w_mis = 1'b1;
        endcase
    end

    assign o_misaligned = CHECK_EN & w_mis;

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit between the memory stage and a big-endian, byte-addressed,
// whole-word-write 32-bit data memory. One request at a time; sub-word stores
// are done as read-modify-write. All outputs are registered.
//
// Build option: DMEM_LSU_ALIGN_CHECK_EN
//   defined   : misaligned / reserved-size requests are answered with rsp_err
//               after one cycle without touching memory
//   undefined : rsp_err stays 0, addresses are forced to natural alignment
//               and the reserved size is handled as a word
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, req_size, req_signed, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err                        one-cycle response
//   mem_addr, mem_data, r_w, MStrobe                     memory command
//   mem_out, PCReady                                     memory read data/ready
// -----------------------------------------------------------------------------
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int AW = 32
)
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data,
    output logic          r_w,
    output logic          MStrobe,
    input  logic [31:0]   mem_out,
    input  logic          PCReady
);

`ifdef DMEM_LSU_ALIGN_CHECK_EN
    localparam bit LSU_CHECK_EN = 1'b1;
`else
    localparam bit LSU_CHECK_EN = 1'b0;
`endif

    state_t        r_state;
    logic [1:0]    r_size;
    logic [1:0]    r_off;
    logic          r_signed;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic          r_mstrobe;
    logic          r_rw;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_data;

    logic [1:0]    w_size_n;
    logic [1:0]    w_off_n;
    logic [AW-1:0] w_word_addr;
    logic [31:0]   w_ext;
    logic [31:0]   w_merged;
    logic          w_misaligned;

    assign w_size_n    = norm_size(req_size);
    assign w_off_n     = norm_off(w_size_n, req_addr[1:0]);
    assign w_word_addr = {req_addr[AW-1:2], 2'b00};

    // Extract/merge act on the latched request and the live memory read data
    dmem_lsu_lane #(
        .CHECK_EN (LSU_CHECK_EN)
    ) u_lane (
        .i_req_size   (req_size),
        .i_req_off    (req_addr[1:0]),
        .i_size       (r_size),
        .i_off        (r_off),
        .i_signed     (r_signed),
        .i_rdata      (mem_out),
        .i_wdata      (r_wdata),
        .o_ext        (w_ext),
        .o_merged     (w_merged),
        .o_misaligned (w_misaligned)
    );

    // Request FSM and every registered output
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_signed    <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= 32'h0000_0000;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_mstrobe   <= 1'b0;
            r_rw        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_size      <= w_size_n;
                        r_off       <= w_off_n;
                        r_signed    <= req_signed;
                        r_we        <= req_we;
                        r_wdata     <= req_wdata;
                        if (w_misaligned) begin
                            // Rejected without any memory access
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0000_0000;
                        end else if (req_we && (w_size_n == SZ_WORD)) begin
                            // Full-word store needs no read
                            r_state    <= ST_WR;
                            r_mstrobe  <= 1'b1;
                            r_rw       <= 1'b1;
                            r_mem_addr <= w_word_addr;
                            r_mem_data <= req_wdata;
                        end else begin
                            r_state    <= ST_RD;
                            r_mstrobe  <= 1'b1;
                            r_rw       <= 1'b0;
                            r_mem_addr <= w_word_addr;
                        end
                    end
                end
                ST_RD: begin
                    if (PCReady) begin
                        if (r_we) begin
                            // Read half of a read-modify-write
                            r_state    <= ST_WR;
                            r_rw       <= 1'b1;
                            r_mem_data <= w_merged;
                        end else begin
                            r_state     <= ST_RESP;
                            r_mstrobe   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_ext;
                            r_rsp_err   <= 1'b0;
                        end
                    end
                end
                ST_WR: begin
                    if (PCReady) begin
                        r_state     <= ST_RESP;
                        r_mstrobe   <= 1'b0;
                        r_rw        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'h0000_0000;
                        r_rsp_err   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'h0000_0000;
                    r_rsp_err   <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_mstrobe   <= 1'b0;
                    r_rw        <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign r_w       = r_rw;
    assign MStrobe   = r_mstrobe;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Directed, table-driven bench for dmem_lsu with a word-wide memory model.
// Expectations for misaligned requests follow DMEM_LSU_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int AW = 32;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          r_w;
    logic          MStrobe;
    logic [31:0]   mem_out;
    logic          PCReady;

    dmem_lsu #(.AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .r_w        (r_w),
        .MStrobe    (MStrobe),
        .mem_out    (mem_out),
        .PCReady    (PCReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide memory: combinational read, write at the edge ending a ready WR cycle
    logic [31:0] mem [0:255];
    assign mem_out = mem[8'(mem_addr >> 2)];
    always @(posedge clk) begin
        if (MStrobe && r_w && PCReady) mem[8'(mem_addr >> 2)] <= mem_data;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          stall;
    } vec_t;

    vec_t vecs [25];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, measure latency from the acceptance edge, check response
    task automatic run_req(input string tag, input vec_t v);
        int          lat;
        int          stb;
        int          w;
        logic        got;
        logic        stable;
        logic        prev_stall;
        logic [65:0] snap;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        PCReady    = (v.stall == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (v.exp_lat > 1) chk({tag, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
        lat = 1; stb = 0; got = 1'b0; stable = 1'b1; prev_stall = 1'b0; snap = '0;
        for (int k = 0; k < 40; k++) begin
            if (prev_stall && ({MStrobe, r_w, mem_addr, mem_data} != snap)) stable = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (MStrobe) stb++;
            if (lat == v.stall + 1) PCReady = 1'b1;
            prev_stall = !PCReady;
            snap = {MStrobe, r_w, mem_addr, mem_data};
            @(posedge clk);
            #1;
            lat++;
        end
        PCReady = 1'b1;
        chk({tag, " rsp_seen"}, {31'd0, got}, 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk({tag, " strobe_cycles"}, 32'(stb), 32'(v.exp_lat - 1));
        if (v.stall > 0) chk({tag, " stall_stable"}, {31'd0, stable}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " pulse_end"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, " MStrobe"}, {31'd0, MStrobe}, 32'd0);
        chk({tag, " r_w"}, {31'd0, r_w}, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'h0);
        chk({tag, " mem_data"}, mem_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        logic        seen;
        vec_t        rv;

        //              we    size     sgn   addr       wdata         exp_rdata     err  lat stall
        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0};
        vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vecs[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h200, 32'h11223344, 32'h00000000, 1'b0, 2, 0};
        vecs[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h201, 32'h0,        32'h00000022, 1'b0, 2, 0};
        vecs[4]  = '{1'b1, SZ_WORD, 1'b0, 32'h200, 32'h11F23344, 32'h00000000, 1'b0, 2, 0};
        vecs[5]  = '{1'b0, SZ_BYTE, 1'b1, 32'h201, 32'h0,        32'hFFFFFFF2, 1'b0, 2, 0};
        vecs[6]  = '{1'b0, SZ_BYTE, 1'b0, 32'h201, 32'h0,        32'h000000F2, 1'b0, 2, 0};
        vecs[7]  = '{1'b1, SZ_WORD, 1'b0, 32'h200, 32'h11223344, 32'h00000000, 1'b0, 2, 0};
        vecs[8]  = '{1'b1, SZ_BYTE, 1'b0, 32'h203, 32'h123456AA, 32'h00000000, 1'b0, 3, 0};
        vecs[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0,        32'h112233AA, 1'b0, 2, 0};
        vecs[10] = '{1'b1, SZ_HALF, 1'b0, 32'h200, 32'hCAFEBEEF, 32'h00000000, 1'b0, 3, 0};
        vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0,        32'hBEEF33AA, 1'b0, 2, 0};
        vecs[12] = '{1'b0, SZ_HALF, 1'b1, 32'h202, 32'h0,        32'h000033AA, 1'b0, 2, 0};
        vecs[13] = '{1'b0, SZ_HALF, 1'b1, 32'h200, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0};
        vecs[14] = '{1'b0, SZ_HALF, 1'b0, 32'h200, 32'h0,        32'h0000BEEF, 1'b0, 2, 0};
        vecs[15] = '{1'b0, SZ_BYTE, 1'b1, 32'h200, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 0};
        vecs[16] = '{1'b0, SZ_BYTE, 1'b0, 32'h203, 32'h0,        32'h000000AA, 1'b0, 2, 0};
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        vecs[17] = '{1'b0, SZ_HALF, 1'b0, 32'h201, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[18] = '{1'b0, SZ_WORD, 1'b0, 32'h202, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[19] = '{1'b0, SZ_RSVD, 1'b0, 32'h200, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[20] = '{1'b1, SZ_HALF, 1'b0, 32'h203, 32'h00001234, 32'h00000000, 1'b1, 1, 0};
        vecs[21] = '{1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0,        32'hBEEF33AA, 1'b0, 2, 0};
`else
        vecs[17] = '{1'b0, SZ_HALF, 1'b0, 32'h201, 32'h0,        32'h0000BEEF, 1'b0, 2, 0};
        vecs[18] = '{1'b0, SZ_WORD, 1'b0, 32'h202, 32'h0,        32'hBEEF33AA, 1'b0, 2, 0};
        vecs[19] = '{1'b0, SZ_RSVD, 1'b0, 32'h200, 32'h0,        32'hBEEF33AA, 1'b0, 2, 0};
        vecs[20] = '{1'b1, SZ_HALF, 1'b0, 32'h203, 32'h00001234, 32'h00000000, 1'b0, 3, 0};
        vecs[21] = '{1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0,        32'hBEEF1234, 1'b0, 2, 0};
`endif
        vecs[22] = '{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 5, 3};
        vecs[23] = '{1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h00000077, 32'h00000000, 1'b0, 5, 2};
        vecs[24] = '{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,        32'hDE77BEEF, 1'b0, 2, 0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        PCReady    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            run_req($sformatf("v%0d", i), vecs[i]);
        end

        // Reset during the read half of a byte store: no write, no response
        saved = mem[8'h80];
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        req_addr   = 32'h201;
        req_wdata  = 32'h00000055;
        PCReady    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rst_in_rd MStrobe", {31'd0, MStrobe}, 32'd1);
        chk("rst_in_rd r_w", {31'd0, r_w}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_mid");
        seen = rsp_valid;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_mid no_rsp", {31'd0, seen}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        seen = rsp_valid;
        chk("rst_mid no_rsp_after", {31'd0, seen}, 32'd0);
        chk("rst_mid mem_kept", mem[8'h80], saved);
        rv = '{1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0, saved, 1'b0, 2, 0};
        run_req("post_rst", rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
